// File: rtl/tfm_pkg.sv
// Shared types for the local-bus write scheduler: chip ids, FSM states, FIFO entry.
package tfm_pkg;

  localparam logic [1:0] CHIP_YM0  = 2'd0;
  localparam logic [1:0] CHIP_YM1  = 2'd1;
  localparam logic [1:0] CHIP_SAA  = 2'd2;
  localparam logic [1:0] CHIP_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

  typedef struct packed {
    logic [1:0] chip;
    logic       a0;
    logic [7:0] data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  // One-hot {SAA, YM1, YM0} select; the reserved id selects nothing.
  function automatic logic [2:0] chip_sel(input logic [1:0] chip);
    logic [2:0] sel;
    case (chip)
      CHIP_YM0: sel = 3'b001;
      CHIP_YM1: sel = 3'b010;
      CHIP_SAA: sel = 3'b100;
      default:  sel = 3'b000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/lb_fifo.sv
// In-order FIFO holding pending local-bus writes; a push while full is dropped.
module lb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == LW'(DEPTH));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + LW'(1);
    else if (pop_ok && !push_ok) count_d = count_q - LW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ym_wr_sched.sv
// Replays buffered YM2203/SAA register writes onto the local bus with fixed
// setup/strobe/hold timing and per-chip recovery holdoff.
//   state     | meaning
//   ST_IDLE   | bus released; waiting for a head entry whose chip is not in holdoff
//   ST_SETUP  | CS, A0 and data driven, WR high (T_SETUP cycles)
//   ST_STROBE | WR low for the selected chip (T_WR cycles)
//   ST_HOLD   | WR high, CS/data still driven; pop and load holdoff on exit
module ym_wr_sched
  import tfm_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int T_SETUP  = 2,
  parameter int T_WR     = 4,
  parameter int YM_AWAIT = 192,
  parameter int YM_DWAIT = 1328,
  parameter int SAA_WAIT = 4,
  parameter int CW       = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_chip,
  input  logic                   req_a0,
  input  logic [7:0]             req_data,
  output logic [7:0]             lb_d,
  output logic                   lb_doe,
  output logic                   lb_a0,
  output logic                   ymcs0_n,
  output logic                   ymcs1_n,
  output logic                   saacs_n,
  output logic                   ymwr_n,
  output logic                   saawr_n,
  output logic [2:0]             busy,
  output logic                   idle,
  output logic [$clog2(DEPTH):0] level
);

  localparam int TMAX = (T_SETUP > T_WR) ? T_SETUP : T_WR;
  localparam int PW   = $clog2(TMAX + 1);

  entry_t               req_ent, head;
  logic [ENTRY_W-1:0]   head_raw;
  logic                 fifo_full, fifo_empty, pop, load, head_free;
  logic [CW-1:0]        load_val;
  logic [CW-1:0]        holdoff_q [3];
  logic [CW-1:0]        holdoff_d [3];

  state_t     state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [1:0] cur_chip_q, cur_chip_d;
  logic       cur_a0_q, cur_a0_d;
  logic [7:0] lb_d_q, lb_d_d;
  logic       lb_doe_q, lb_doe_d, lb_a0_q, lb_a0_d;
  logic [2:0] cs_n_q, cs_n_d;
  logic       ymwr_n_q, ymwr_n_d, saawr_n_q, saawr_n_d;

  assign req_ent = '{chip: req_chip, a0: req_a0, data: req_data};
  assign head    = entry_t'(head_raw);

  lb_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_valid),
    .din   (req_ent),
    .pop   (pop),
    .dout  (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign req_ready = !fifo_full;
  assign busy      = {holdoff_q[2] != '0, holdoff_q[1] != '0, holdoff_q[0] != '0};
  assign idle      = fifo_empty && (state_q == ST_IDLE) && (busy == 3'b000);
  assign {saacs_n, ymcs1_n, ymcs0_n} = cs_n_q;
  assign ymwr_n  = ymwr_n_q;
  assign saawr_n = saawr_n_q;
  assign lb_d    = lb_d_q;
  assign lb_doe  = lb_doe_q;
  assign lb_a0   = lb_a0_q;

  // Holdoff of 1 expires on this edge, so the next cycle may start right now.
  always_comb begin
    case (head.chip)
      CHIP_YM0: head_free = (holdoff_q[0] <= CW'(1));
      CHIP_YM1: head_free = (holdoff_q[1] <= CW'(1));
      CHIP_SAA: head_free = (holdoff_q[2] <= CW'(1));
      default:  head_free = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_chip_d = cur_chip_q;
    cur_a0_d   = cur_a0_q;
    lb_d_d     = lb_d_q;
    lb_doe_d   = lb_doe_q;
    lb_a0_d    = lb_a0_q;
    cs_n_d     = cs_n_q;
    ymwr_n_d   = ymwr_n_q;
    saawr_n_d  = saawr_n_q;
    pop        = 1'b0;
    load       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (head.chip == CHIP_RSVD) begin
            pop = 1'b1;
          end else if (head_free) begin
            state_d    = ST_SETUP;
            cnt_d      = PW'(T_SETUP - 1);
            cur_chip_d = head.chip;
            cur_a0_d   = head.a0;
            lb_d_d     = head.data;
            lb_a0_d    = head.a0;
            lb_doe_d   = 1'b1;
            cs_n_d     = ~chip_sel(head.chip);
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = PW'(T_WR - 1);
          if (cur_chip_q == CHIP_SAA) saawr_n_d = 1'b0;
          else                        ymwr_n_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - PW'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d   = ST_HOLD;
          ymwr_n_d  = 1'b1;
          saawr_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q - PW'(1);
        end
      end
      ST_HOLD: begin
        pop      = 1'b1;
        load     = 1'b1;
        state_d  = ST_IDLE;
        cs_n_d   = 3'b111;
        lb_doe_d = 1'b0;
        lb_d_d   = 8'h00;
        lb_a0_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cur_chip_q <= CHIP_YM0;
      cur_a0_q   <= 1'b0;
      lb_d_q     <= 8'h00;
      lb_doe_q   <= 1'b0;
      lb_a0_q    <= 1'b0;
      cs_n_q     <= 3'b111;
      ymwr_n_q   <= 1'b1;
      saawr_n_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_chip_q <= cur_chip_d;
      cur_a0_q   <= cur_a0_d;
      lb_d_q     <= lb_d_d;
      lb_doe_q   <= lb_doe_d;
      lb_a0_q    <= lb_a0_d;
      cs_n_q     <= cs_n_d;
      ymwr_n_q   <= ymwr_n_d;
      saawr_n_q  <= saawr_n_d;
    end
  end

  assign load_val = (cur_chip_q == CHIP_SAA) ? CW'(SAA_WAIT) :
                    cur_a0_q                 ? CW'(YM_DWAIT) : CW'(YM_AWAIT);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      holdoff_d[i] = (holdoff_q[i] != '0) ? holdoff_q[i] - CW'(1) : '0;
    end
    if (load) begin
      case (cur_chip_q)
        CHIP_YM0: holdoff_d[0] = load_val;
        CHIP_YM1: holdoff_d[1] = load_val;
        CHIP_SAA: holdoff_d[2] = load_val;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) holdoff_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) holdoff_q[i] <= holdoff_d[i];
    end
  end

endmodule

// File: doc/ym_wr_sched.md
Name: ym_wr_sched

Overview:
- Write scheduler for the local YM2203/SAA bus.
- Buffers register writes (chip id, A0, data) from the Speccy-side bus controller in a small in-order FIFO.
- Replays each write onto the local bus with fixed setup/strobe/hold timing.
- Enforces per-chip recovery (busy) times, so the Z80 never has to poll YM status between writes.

Parameters:
- DEPTH, 4: FIFO entries; power of 2, min 2.
- T_SETUP, 2: fclk cycles CS/A0/data valid before WR falls; min 1.
- T_WR, 4: fclk cycles WR held low; min 1.
- YM_AWAIT, 192: fclk recovery after a YM address write (A0=0); 12 ymclk × 16.
- YM_DWAIT, 1328: fclk recovery after a YM data write (A0=1); 83 ymclk × 16.
- SAA_WAIT, 4: fclk recovery after any SAA write.
- CW, 11: holdoff counter width; must hold max(YM_AWAIT, YM_DWAIT, SAA_WAIT).

Ports:
- clk  in  1  fclk 56 MHz
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  write request present
- req_ready  out  1  FIFO can accept; transfer when req_valid & req_ready at clk edge
- req_chip  in  2  target: 0 = YM0, 1 = YM1, 2 = SAA, 3 = reserved
- req_a0  in  1  address/data select
- req_data  in  8  register address or data byte
- lb_d  out  8  local data bus value
- lb_doe  out  1  drive enable for lb_d
- lb_a0  out  1  to yma0/saaa0
- ymcs0_n, ymcs1_n, saacs_n  out  1 each  chip selects
- ymwr_n, saawr_n  out  1 each  write strobes
- busy  out  3  per-chip holdoff nonzero, {SAA, YM1, YM0}
- idle  out  1  FIFO empty & state IDLE & busy==0
- level  out  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, immediate):
  - all _n outputs 1; lb_doe=0; lb_d=0; lb_a0=0.
  - FIFO empty; level=0; req_ready=1; holdoffs 0; busy=0; idle=1; state IDLE.
  - Reset mid-cycle aborts it; the entry is lost.
- FIFO:
  - req_ready = (level != DEPTH).
  - Push when full is not accepted, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: level unchanged.
  - Pointers wrap modulo DEPTH.
  - Strict in-order: a busy head blocks later entries for other chips (no reordering).
- FSM states: IDLE, SETUP, STROBE, HOLD.
  - IDLE:
    - FIFO nonempty & head chip in 0..2 & holdoff[head chip]==0 -> SETUP.
    - Head chip==3 -> pop silently, stay IDLE; no bus activity, no holdoff.
  - SETUP (T_SETUP cycles):
    - selected CS=0; lb_a0=head.a0; lb_d=head.data; lb_doe=1.
    - -> STROBE.
  - STROBE (T_WR cycles): as SETUP, plus ymwr_n=0 (YM0/YM1) or saawr_n=0 (SAA) -> HOLD.
  - HOLD (1 cycle):
    - WR=1; CS=0; data still driven.
    - At exit: pop; load holdoff[chip] = YM_AWAIT (YM, A0=0), YM_DWAIT (YM, A0=1) or SAA_WAIT (SAA).
    - -> IDLE with all CS=1, lb_doe=0.
- Latency: push accepted at edge N, FIFO empty, holdoff 0:
  - CS falls at edge N+1.
  - WR falls at N+1+T_SETUP and rises at N+1+T_SETUP+T_WR.
  - CS rises at N+2+T_SETUP+T_WR.
  - Back-to-back writes to a different, non-busy chip: CS high for exactly 1 cycle between them.
- Holdoff counters:
  - Independent per chip; decrement by 1 each clk while nonzero; saturate at 0.
  - A load in the same cycle overrides the decrement.
  - busy[i] = holdoff[i]!=0.
- Outputs are registered (glitch-free strobes); at most one CS low at any time.

Decomposition:
- Package tfm_pkg:
  - chip id constants CHIP_YM0/YM1/SAA/RSVD.
  - FSM state encoding.
  - FIFO entry struct {chip[1:0], a0, data[7:0]} = 11 bits.
- One sub-module, lb_fifo: synchronous FIFO (DEPTH, width 11; push/pop/full/empty/level).
- Scheduler FSM and holdoff counters stay in ym_wr_sched.

Test Plan:
- Single YM0 write, a0=0, data=0x28 -> ymcs0_n low 7 cycles from N+1; ymwr_n low cycles N+3..N+6; lb_d=0x28; busy[0]=1 for 192 cycles; idle returns 1 after.
- YM0 addr then YM0 data pushed back-to-back -> second CS falls exactly 192 cycles after the first HOLD pop; data write then sets busy[0] for 1328 cycles.
- Pushes YM0(a0=1), YM1(a0=0), SAA(a0=0) -> YM1 cycle starts 1 cycle after YM0 ends (no wait on YM0 busy); SAA follows likewise; only one CS low at a time.
- 5 pushes with DEPTH=4 while head is blocked by busy -> req_ready=0 at level=4; 5th held off; push with simultaneous pop at full is refused; all 4 entries replayed in order.
- req_chip=3 entry between two YM1 writes -> no strobe, no holdoff; next YM1 write waits only on YM1 holdoff.
- rst_n asserted during STROBE -> ymwr_n/CS go 1 and lb_doe 0 asynchronously; level=0; busy=0; fresh write after release behaves as the first scenario.
